ahblite_interconnect_arbiter_nport: RTL and testbench

Registered N-master arbiter for the AHB-Lite interconnect. It picks one requesting master per arbitration point using either programmable fixed priority (n-bit priority compare) or round-robin. It holds the grant across bursts, locked transfers and wait states. It sits ahead of the interconnect address mux and drives its select.

---
 rtl/ahblite_interconnect_arbiter_nport.sv | 70 +++++++
 tb/tb_ahblite_interconnect_arbiter_nport.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ahblite_interconnect_arbiter_nport.sv
// ahblite_interconnect_arbiter_nport: registered N-master AHB-Lite arbiter, fixed-priority or round-robin, holding grant across bursts, locks and wait states.
module ahblite_interconnect_arbiter_nport #(
  parameter int NUM_MASTER     = 4,
  parameter int PRIO_WIDTH     = 2,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                               HCLK,
  input  logic                               HRESETn,
  input  logic [NUM_MASTER-1:0]              req_i,
  input  logic [NUM_MASTER*PRIO_WIDTH-1:0]   prio_i,
  input  logic                               mode_i,
  input  logic [1:0]                         htrans_i,
  input  logic                               hmastlock_i,
  input  logic                               hready_i,
  output logic [NUM_MASTER-1:0]              grant_o,
  output logic [$clog2(NUM_MASTER)-1:0]      grant_idx_o,
  output logic                               grant_valid_o
);
  localparam int IW = $clog2(NUM_MASTER);
  localparam logic [IW:0] NM = (IW+1)'(NUM_MASTER);
  localparam logic [IW-1:0] DEF = IW'(DEFAULT_MASTER);
  logic [IW-1:0] idx_q, idx_d, rr_last_q, rr_last_d, fp_idx, rr_idx;
  logic [NUM_MASTER-1:0] grant_q, grant_d;
  logic valid_q, valid_d, any_req, arb, fp_found;
  logic [PRIO_WIDTH-1:0] best;
  logic [IW:0] cand;
  assign any_req = |req_i;
  assign arb = hready_i && !(hmastlock_i || htrans_i == 2'b11 || htrans_i == 2'b01);
  // strict greater-than keeps the lowest index on priority ties
  always_comb begin
    fp_idx = '0;
    fp_found = 1'b0;
    best = '0;
    for (int k = 0; k < NUM_MASTER; k++)
      if (req_i[k] && (!fp_found || prio_i[k*PRIO_WIDTH +: PRIO_WIDTH] > best)) begin
        fp_found = 1'b1;
        best = prio_i[k*PRIO_WIDTH +: PRIO_WIDTH];
        fp_idx = IW'(k);
      end
  end
  // scan the rotation backwards so the last hit is the first requester after rr_last
  always_comb begin
    rr_idx = '0;
    cand = '0;
    for (int i = NUM_MASTER; i >= 1; i--) begin
      cand = {1'b0, rr_last_q} + (IW+1)'(i);
      cand = cand >= NM ? cand - NM : cand;
      if (req_i[cand[IW-1:0]]) rr_idx = cand[IW-1:0];
    end
  end
  assign idx_d = !arb ? idx_q : !any_req ? DEF : mode_i ? rr_idx : fp_idx;
  assign valid_d = arb ? any_req : valid_q;
  assign rr_last_d = arb && any_req ? idx_d : rr_last_q;
  assign grant_d = NUM_MASTER'(1) << idx_d;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      grant_q   <= NUM_MASTER'(1) << DEF;
      idx_q     <= DEF;
      valid_q   <= 1'b0;
      rr_last_q <= IW'(NUM_MASTER-1);
    end else begin
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      rr_last_q <= rr_last_d;
    end
  assign grant_o = grant_q;
  assign grant_idx_o = idx_q;
  assign grant_valid_o = valid_q;
endmodule

// File: tb/tb_ahblite_interconnect_arbiter_nport.sv
// tb_ahblite_interconnect_arbiter_nport: directed and randomized checks of the arbiter against a rule-level reference model.
module tb_ahblite_interconnect_arbiter_nport;
  localparam int N = 4, PW = 2, DEF = 2;
  logic HCLK = 0, HRESETn = 0;
  logic [N-1:0] req_i = '0;
  logic [N*PW-1:0] prio_i = '0;
  logic mode_i = 0, hmastlock_i = 0, hready_i = 1;
  logic [1:0] htrans_i = 2'b00;
  logic [N-1:0] grant_o;
  logic [1:0] grant_idx_o;
  logic grant_valid_o;
  int checks = 0, failures = 0;
  int m_idx = DEF, m_last = N-1;
  bit m_valid = 0;

  ahblite_interconnect_arbiter_nport #(.NUM_MASTER(N), .PRIO_WIDTH(PW), .DEFAULT_MASTER(DEF)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_i(req_i), .prio_i(prio_i), .mode_i(mode_i),
    .htrans_i(htrans_i), .hmastlock_i(hmastlock_i), .hready_i(hready_i),
    .grant_o(grant_o), .grant_idx_o(grant_idx_o), .grant_valid_o(grant_valid_o));

  always #5 HCLK = ~HCLK;

  function automatic int fixed_winner(input logic [N-1:0] r, input logic [N*PW-1:0] p);
    int top = -1;
    for (int k = 0; k < N; k++) if (r[k] && int'(p[k*PW +: PW]) > top) top = int'(p[k*PW +: PW]);
    for (int k = 0; k < N; k++) if (r[k] && int'(p[k*PW +: PW]) == top) return k;
    return -1;
  endfunction

  function automatic int rr_winner(input logic [N-1:0] r, input int last);
    for (int s = 1; s <= N; s++) if (r[(last + s) % N]) return (last + s) % N;
    return -1;
  endfunction

  task automatic model_step();
    int w;
    if (hready_i && !hmastlock_i && htrans_i != 2'b11 && htrans_i != 2'b01) begin
      w = mode_i ? rr_winner(req_i, m_last) : fixed_winner(req_i, prio_i);
      if (w < 0) begin m_idx = DEF; m_valid = 0; end
      else begin m_idx = w; m_valid = 1; m_last = w; end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic do_reset();
    #2 HRESETn = 0;
    m_idx = DEF; m_valid = 0; m_last = N-1;
    htrans_i = 2'b00; hmastlock_i = 0; hready_i = 1;
    @(negedge HCLK);
    HRESETn = 1;
  endtask

  task automatic test_reset();
    do_reset();
    mode_i = 0; req_i = 4'b0001; prio_i = '0; htrans_i = 2'b10;
    tick();
    checks++;
    if (grant_idx_o !== 2'd0) begin failures++; $display("FAIL reset_pre_idx: got %0d want 0", grant_idx_o); end
    req_i = 4'b1111; htrans_i = 2'b11;
    #2 HRESETn = 0;
    m_idx = DEF; m_valid = 0; m_last = N-1;
    #1;
    checks++;
    if (grant_o !== 4'b0100) begin failures++; $display("FAIL reset_grant: got %b want 0100", grant_o); end
    checks++;
    if (grant_idx_o !== 2'd2) begin failures++; $display("FAIL reset_idx: got %0d want 2", grant_idx_o); end
    checks++;
    if (grant_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", grant_valid_o); end
    @(negedge HCLK);
    HRESETn = 1; htrans_i = 2'b00; req_i = '0;
  endtask

  task automatic test_fixed_priority();
    logic [N-1:0] reqs [3] = '{4'b1011, 4'b1011, 4'b0110};
    logic [N*PW-1:0] prios [3] = '{{2'd1, 2'd0, 2'd3, 2'd3}, {2'd3, 2'd0, 2'd2, 2'd2}, {2'd3, 2'd1, 2'd1, 2'd0}};
    logic [N-1:0] exp_g [3] = '{4'b0001, 4'b1000, 4'b0010};
    logic [1:0] exp_i [3] = '{2'd0, 2'd3, 2'd1};
    mode_i = 0; htrans_i = 2'b00; hready_i = 1;
    for (int t = 0; t < 3; t++) begin
      req_i = reqs[t]; prio_i = prios[t];
      tick();
      checks++;
      if (grant_o !== exp_g[t]) begin failures++; $display("FAIL fixed_grant[%0d]: got %b want %b", t, grant_o, exp_g[t]); end
      checks++;
      if (grant_idx_o !== exp_i[t] || grant_valid_o !== 1'b1) begin
        failures++; $display("FAIL fixed_idx[%0d]: got %0d/%b want %0d/1", t, grant_idx_o, grant_valid_o, exp_i[t]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_i [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    mode_i = 1; req_i = 4'b1111; htrans_i = 2'b10;
    for (int t = 0; t < 5; t++) begin
      tick();
      checks++;
      if (grant_idx_o !== exp_i[t]) begin failures++; $display("FAIL rr_seq[%0d]: got %0d want %0d", t, grant_idx_o, exp_i[t]); end
    end
  endtask

  task automatic test_burst_hold();
    logic [1:0] tr [5] = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b00};
    logic rdy [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    mode_i = 0; req_i = 4'b0010; prio_i = '0; htrans_i = 2'b10;
    tick();
    checks++;
    if (grant_o !== 4'b0010) begin failures++; $display("FAIL burst_setup: got %b want 0010", grant_o); end
    req_i = 4'b1010; prio_i = {2'd3, 2'd0, 2'd1, 2'd0};
    for (int t = 0; t < 5; t++) begin
      htrans_i = tr[t]; hready_i = rdy[t]; mode_i = t[0];
      tick();
      checks++;
      if (grant_o !== 4'b0010) begin failures++; $display("FAIL burst_hold[%0d]: got %b want 0010", t, grant_o); end
    end
    mode_i = 0; htrans_i = 2'b10; hready_i = 1;
    tick();
    checks++;
    if (grant_o !== 4'b1000 || grant_idx_o !== 2'd3) begin failures++; $display("FAIL burst_release: got %b/%0d want 1000/3", grant_o, grant_idx_o); end
  endtask

  task automatic test_lock_hold();
    req_i = 4'b1001; prio_i = {2'd1, 2'd0, 2'd0, 2'd3}; hmastlock_i = 1; htrans_i = 2'b10; hready_i = 1;
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++;
      if (grant_o !== 4'b1000) begin failures++; $display("FAIL lock_hold[%0d]: got %b want 1000", t, grant_o); end
    end
    hmastlock_i = 0;
    tick();
    checks++;
    if (grant_o !== 4'b0001) begin failures++; $display("FAIL lock_release: got %b want 0001", grant_o); end
  endtask

  task automatic test_idle_parking();
    do_reset();
    mode_i = 1; req_i = 4'b1111; htrans_i = 2'b10;
    tick();
    tick();
    checks++;
    if (grant_idx_o !== 2'd1) begin failures++; $display("FAIL park_setup: got %0d want 1", grant_idx_o); end
    req_i = '0;
    tick();
    checks++;
    if (grant_o !== 4'b0100 || grant_idx_o !== 2'd2 || grant_valid_o !== 1'b0) begin
      failures++; $display("FAIL park_idle: got %b/%0d/%b want 0100/2/0", grant_o, grant_idx_o, grant_valid_o);
    end
    req_i = 4'b1111;
    tick();
    checks++;
    if (grant_idx_o !== 2'd2 || grant_valid_o !== 1'b1) begin
      failures++; $display("FAIL park_resume: got %0d/%b want 2/1", grant_idx_o, grant_valid_o);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      req_i = N'($urandom);
      if ($urandom_range(0, 7) == 0) req_i = '0;
      prio_i = (N*PW)'($urandom);
      if ($urandom_range(0, 9) == 0) mode_i = ~mode_i;
      htrans_i = 2'($urandom);
      hmastlock_i = $urandom_range(0, 5) == 0;
      hready_i = $urandom_range(0, 3) != 0;
      tick();
      checks++;
      if (grant_idx_o !== 2'(m_idx) || grant_valid_o !== m_valid || grant_o !== 4'(1 << m_idx)) begin
        failures++;
        $display("FAIL rand[%0d]: got grant=%b idx=%0d valid=%b want grant=%b idx=%0d valid=%b",
                 c, grant_o, grant_idx_o, grant_valid_o, 4'(1 << m_idx), m_idx, m_valid);
      end
    end
  endtask

  initial begin
    @(negedge HCLK);
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_burst_hold();
    test_lock_hold();
    test_idle_parking();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
